// File: rtl/alu_exec_unit_if.sv
// Request/result bundle of the ALU execution unit.
// Both channels are valid/ready: a beat transfers on a rising edge where valid & ready are both 1;
// the source holds its payload and keeps valid high until that edge, and ready may depend on state.
interface alu_exec_unit_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       alu_ctrl;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             illegal;

  modport master (
    output in_valid, alu_ctrl, src_a, src_b, out_ready,
    input  in_ready, out_valid, result, zero, illegal
  );

  modport slave (
    input  in_valid, alu_ctrl, src_a, src_b, out_ready,
    output in_ready, out_valid, result, zero, illegal
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Single-issue ALU: one-cycle logic/arithmetic ops, bit-serial shifts (one bit per cycle),
// result held in DONE until the consumer takes it; flush aborts anything in flight.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           flush,
  alu_exec_unit_if.slave bus,
  output logic [1:0]     state_dbg
);
  localparam int SW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] work, work_nxt, result_q, alu_res;
  logic [SW-1:0]    cnt, shamt;
  logic             dir_right, illegal_q, accept, is_shift, go_shift;

  assign bus.in_ready  = (state == IDLE) & ~flush;
  assign bus.out_valid = (state == DONE);
  assign bus.result    = result_q;
  assign bus.zero      = (result_q == '0);
  assign bus.illegal   = illegal_q;
  assign state_dbg     = state;

  assign shamt    = bus.src_b[SW-1:0];
  assign is_shift = (bus.alu_ctrl[2:1] == 2'b11);
  assign accept   = bus.in_valid & bus.in_ready;
  assign go_shift = is_shift & (shamt != '0);
  assign work_nxt = dir_right ? (work >> 1) : (work << 1);

  // Single-cycle results; shift codes only land here when shamt is 0, so they pass src_a.
  always_comb begin
    alu_res = '0;
    case (bus.alu_ctrl)
      3'b000:  alu_res = bus.src_a + bus.src_b;
      3'b001:  alu_res = bus.src_a - bus.src_b;
      3'b010:  alu_res = bus.src_a & bus.src_b;
      3'b011:  alu_res = bus.src_a | bus.src_b;
      3'b101:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.src_a) < $signed(bus.src_b))};
      3'b110:  alu_res = bus.src_a;
      3'b111:  alu_res = bus.src_a;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_nxt = go_shift ? SHIFT : DONE;
        SHIFT:   if (cnt == SW'(1)) state_nxt = DONE;
        DONE:    if (bus.out_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs only change when an operation completes; flush drops illegal but keeps result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      work      <= '0;
      cnt       <= '0;
      dir_right <= 1'b0;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else if (flush) begin
      illegal_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (go_shift) begin
              work      <= bus.src_a;
              cnt       <= shamt;
              dir_right <= bus.alu_ctrl[0];
            end else begin
              result_q  <= alu_res;
              illegal_q <= (bus.alu_ctrl == 3'b100);
            end
          end
        end
        SHIFT: begin
          work <= work_nxt;
          cnt  <= cnt - SW'(1);
          if (cnt == SW'(1)) begin
            result_q  <= work_nxt;
            illegal_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed and randomized checks of alu_exec_unit against a plain-arithmetic reference model.
module tb_alu_exec_unit;
  logic       clk;
  logic       reset_n;
  logic       flush;
  logic [1:0] state_dbg;
  int         checks;
  int         errors;
  logic [31:0] last_res;
  logic        last_ill;
  logic        seen;

  alu_exec_unit_if #(.WIDTH(32)) bus ();

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {illegal, result}
  function automatic logic [32:0] ref_op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (c)
      3'd0: return {1'b0, a + b};
      3'd1: return {1'b0, a - b};
      3'd2: return {1'b0, a & b};
      3'd3: return {1'b0, a | b};
      3'd5: return {1'b0, (($signed(a) < $signed(b)) ? 32'd1 : 32'd0)};
      3'd6: return {1'b0, a << sh};
      3'd7: return {1'b0, a >> sh};
      default: return {1'b1, 32'd0};
    endcase
  endfunction

  // Called at a falling edge with the unit idle; returns at a falling edge, idle again.
  task automatic do_op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [32:0] r;
    int n, edges;
    r = ref_op(c, a, b);
    n = (c == 3'd6 || c == 3'd7) ? int'(b % 32) : 0;
    chk("in_ready_before", bus.in_ready, 1);
    bus.alu_ctrl  = c;
    bus.src_a     = a;
    bus.src_b     = b;
    bus.in_valid  = 1'b1;
    bus.out_ready = (hold == 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.src_a    = $urandom;
    bus.src_b    = $urandom;
    bus.alu_ctrl = 3'($urandom_range(0, 7));
    @(negedge clk);
    edges = 0;
    while (!bus.out_valid && edges < 100) begin
      chk("in_ready_busy", bus.in_ready, 0);
      @(posedge clk); @(negedge clk);
      edges++;
    end
    chk("latency", edges, n);
    chk("out_valid", bus.out_valid, 1);
    chk("result", bus.result, r[31:0]);
    chk("illegal", bus.illegal, r[32]);
    chk("zero", bus.zero, (r[31:0] == 32'd0));
    chk("in_ready_done", bus.in_ready, 0);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); @(negedge clk);
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_result", bus.result, r[31:0]);
      chk("hold_in_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("consumed_valid", bus.out_valid, 0);
    chk("consumed_in_ready", bus.in_ready, 1);
    bus.out_ready = 1'b0;
    last_res = r[31:0];
    last_ill = r[32];
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.alu_ctrl = 3'd0;
    bus.src_a = '0;
    bus.src_b = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_result", bus.result, 0);
    chk("rst_zero", bus.zero, 1);
    chk("rst_illegal", bus.illegal, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    reset_n = 1'b1;
    #1 chk("rst_in_ready", bus.in_ready, 1);
    @(negedge clk);

    // Directed operations
    do_op(3'd0, 32'h7FFF_FFFF, 32'd1, 0);
    do_op(3'd1, 32'd5, 32'd5, 1);
    do_op(3'd5, 32'hFFFF_FFFF, 32'd1, 0);
    do_op(3'd5, 32'd1, 32'hFFFF_FFFF, 0);
    do_op(3'd6, 32'h1, 32'h25, 2);
    do_op(3'd7, 32'h8000_0000, 32'd31, 0);
    do_op(3'd6, 32'hDEAD_BEEF, 32'h40, 0);
    do_op(3'd2, 32'hF0F0_1234, 32'h0FF0_FFFF, 0);
    do_op(3'd3, 32'hF000_0000, 32'h0000_000F, 0);
    do_op(3'd4, $urandom, $urandom, 10);

    // Flush in the middle of a 20-bit shift, at edge T0+7
    chk("fl_in_ready", bus.in_ready, 1);
    bus.alu_ctrl = 3'd6;
    bus.src_a = $urandom | 32'd1;
    bus.src_b = 32'd20;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    repeat (6) begin @(posedge clk); @(negedge clk); end
    chk("fl_illegal_held", bus.illegal, last_ill);
    chk("fl_mid_valid", bus.out_valid, 0);
    flush = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("fl_in_ready_during", bus.in_ready, 0);
    chk("fl_illegal_cleared", bus.illegal, 0);
    chk("fl_result_kept", bus.result, last_res);
    flush = 1'b0;
    #1 chk("fl_idle", bus.in_ready, 1);
    seen = 1'b0;
    repeat (25) begin @(negedge clk); seen |= bus.out_valid; end
    chk("fl_never_valid", seen, 0);

    // Flush together with a request: nothing is accepted
    bus.alu_ctrl = 3'd0;
    bus.src_a = 32'd1;
    bus.src_b = 32'd1;
    bus.in_valid = 1'b1;
    flush = 1'b1;
    #1 chk("flv_in_ready", bus.in_ready, 0);
    @(posedge clk); @(negedge clk);
    bus.in_valid = 1'b0;
    flush = 1'b0;
    seen = 1'b0;
    repeat (5) begin @(negedge clk); seen |= bus.out_valid; end
    chk("flv_no_result", seen, 0);
    chk("flv_result_kept", bus.result, last_res);

    // Asynchronous reset in the middle of a shift
    do_op(3'd0, 32'h1234_5678, 32'h1, 0);
    bus.alu_ctrl = 3'd6;
    bus.src_a = 32'h3;
    bus.src_b = 32'd20;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_result", bus.result, 0);
    chk("ar_zero", bus.zero, 1);
    chk("ar_out_valid", bus.out_valid, 0);
    chk("ar_illegal", bus.illegal, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1 chk("ar_in_ready", bus.in_ready, 1);
    @(negedge clk);
    do_op(3'd0, 32'd2, 32'd3, 0);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      do_op(3'($urandom_range(0, 7)), $urandom, $urandom, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
